// File: rtl/line_select_pkg.sv
// Shared types and helpers for the line select mux.
// FSM state enum plus a clog2-based width helper.
package line_select_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/line_way_select.sv
// Combinational WAYS:1 line selector.
// Selects past the last way return an all-zero line and raise o_oob.
module line_way_select
    import line_select_pkg::*;
#(
    parameter int WAYS   = 8,
    parameter int LINE_W = 512,
    parameter int SEL_W  = width_of(WAYS)
) (
    input  logic [WAYS*LINE_W-1:0] i_way_data,
    input  logic [SEL_W-1:0]       i_sel,
    output logic [LINE_W-1:0]      o_line,
    output logic                   o_oob
);

    always_comb begin
        o_line = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (i_sel == SEL_W'(i)) begin
                o_line = i_way_data[i*LINE_W +: LINE_W];
            end
        end
    end

    assign o_oob = {1'b0, i_sel} >= (SEL_W+1)'(WAYS);

endmodule

// File: rtl/line_select_mux.sv
// Captures one cache-way line and streams it out as BEATS beats.
// LINE_SELECT_CRITICAL_WORD_FIRST_EN: start the burst at req_offset.
module line_select_mux
    import line_select_pkg::*;
#(
    parameter  int WAYS   = 8,
    parameter  int LINE_W = 512,
    parameter  int BEAT_W = 64,
    localparam int BEATS  = LINE_W / BEAT_W,
    localparam int WAY_W  = width_of(WAYS),
    localparam int IDX_W  = width_of(BEATS)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [WAY_W-1:0]       req_way,
    input  logic [IDX_W-1:0]       req_offset,
    input  logic [WAYS*LINE_W-1:0] way_data,
    output logic                   beat_valid,
    input  logic                   beat_ready,
    output logic [BEAT_W-1:0]      beat_data,
    output logic [IDX_W-1:0]       beat_idx,
    output logic                   beat_last,
    output logic                   way_err
);

    state_t r_state;
    state_t w_next;

    logic [LINE_W-1:0]             r_line;
    logic [LINE_W-1:0]             w_sel_line;
    logic                          w_oob;
    logic                          r_err;
    logic [IDX_W-1:0]              r_idx;
    logic [IDX_W-1:0]              r_cnt;
    logic [IDX_W-1:0]              w_start;
    logic                          w_accept;
    logic                          w_beat_hs;
    logic                          w_cnt_last;
    logic [BEATS-1:0][BEAT_W-1:0]  w_beats;

    line_way_select #(
        .WAYS   (WAYS),
        .LINE_W (LINE_W),
        .SEL_W  (WAY_W)
    ) u_way_select (
        .i_way_data (way_data),
        .i_sel      (req_way),
        .o_line     (w_sel_line),
        .o_oob      (w_oob)
    );

`ifdef LINE_SELECT_CRITICAL_WORD_FIRST_EN
    assign w_start = req_offset;
`else
    logic w_unused_offset;
    assign w_unused_offset = ^req_offset;
    assign w_start = '0;
`endif

    assign w_accept   = req_valid && req_ready;
    assign w_beat_hs  = beat_valid && beat_ready;
    assign w_cnt_last = (r_cnt == IDX_W'(BEATS-1));

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:  if (req_valid) w_next = BURST;
            BURST: if (beat_ready && w_cnt_last) w_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (r_state == IDLE);
        beat_valid = (r_state == BURST);
    end

    // The counter tracks beats sent; the index tracks line position.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_line <= '0;
            r_err  <= 1'b0;
            r_idx  <= '0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_line <= w_sel_line;
            r_err  <= w_oob;
            r_idx  <= w_start;
            r_cnt  <= '0;
        end else if (w_beat_hs) begin
            r_idx  <= r_idx + 1'b1;
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    assign w_beats   = r_line;
    assign beat_data = w_beats[r_idx];
    assign beat_idx  = r_idx;
    assign beat_last = (r_state == BURST) && w_cnt_last;
    assign way_err   = r_err;

endmodule

// File: tb/tb_line_select_mux.sv
// Randomized self-checking bench for line_select_mux (WAYS=6, 8 beats).
// Expected beats come from a line/offset model, not the RTL structure.
module tb_line_select_mux;

    localparam int WAYS   = 6;
    localparam int LINE_W = 512;
    localparam int BEAT_W = 64;
    localparam int BEATS  = 8;

    logic                   clock = 1'b0;
    logic                   reset_n;
    logic                   req_valid;
    logic                   req_ready;
    logic [2:0]             req_way;
    logic [2:0]             req_offset;
    logic [WAYS*LINE_W-1:0] way_data;
    logic                   beat_valid;
    logic                   beat_ready;
    logic [BEAT_W-1:0]      beat_data;
    logic [2:0]             beat_idx;
    logic                   beat_last;
    logic                   way_err;

    logic [LINE_W-1:0] ways [8];

    int n_checks = 0;
    int n_pass   = 0;

    logic        obs_valid [64];
    logic        obs_ready [64];
    logic        obs_rreq  [64];
    logic        obs_last  [64];
    logic [2:0]  obs_idx   [64];
    logic [63:0] obs_data  [64];
    int          obs_n;

    logic [2:0]  hs_idx   [BEATS];
    logic [63:0] hs_data  [BEATS];
    logic        hs_last  [BEATS];
    int          hs_cycle [BEATS];
    int          hs_n;

    logic              acc_ready;
    logic [LINE_W-1:0] exp_line;
    int                exp_start;

    line_select_mux #(
        .WAYS   (WAYS),
        .LINE_W (LINE_W),
        .BEAT_W (BEAT_W)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_way    (req_way),
        .req_offset (req_offset),
        .way_data   (way_data),
        .beat_valid (beat_valid),
        .beat_ready (beat_ready),
        .beat_data  (beat_data),
        .beat_idx   (beat_idx),
        .beat_last  (beat_last),
        .way_err    (way_err)
    );

    always #5 clock = ~clock;

    always_comb begin
        way_data = '0;
        for (int i = 0; i < WAYS; i++) begin
            way_data[i*LINE_W +: LINE_W] = ways[i];
        end
    end

    function automatic logic [63:0] beat_of(input logic [LINE_W-1:0] l,
                                            input int b);
        return l[b*BEAT_W +: BEAT_W];
    endfunction

    function automatic logic [LINE_W-1:0] line_of(input int w);
        return (w < WAYS) ? ways[w] : '0;
    endfunction

    function automatic int start_of(input int off);
`ifdef LINE_SELECT_CRITICAL_WORD_FIRST_EN
        return off;
`else
        return 0 * off;
`endif
    endfunction

    task automatic randomize_ways();
        for (int w = 0; w < 8; w++) begin
            for (int b = 0; b < BEATS; b++) begin
                ways[w][b*BEAT_W +: BEAT_W] = {$urandom(), $urandom()};
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Sample one cycle of DUT outputs into the observation buffers.
    task automatic sample(input int c);
        obs_valid[c] = beat_valid;
        obs_ready[c] = beat_ready;
        obs_rreq[c]  = req_ready;
        obs_last[c]  = beat_last;
        obs_idx[c]   = beat_idx;
        obs_data[c]  = beat_data;
    endtask

    task automatic do_burst(input int way, input int off,
                            input int stall_at, input int stall_len,
                            input bit change);
        int stalled = 0;
        @(negedge clock);
        req_valid  = 1'b1;
        req_way    = way[2:0];
        req_offset = off[2:0];
        beat_ready = 1'b1;
        acc_ready  = req_ready;
        exp_line   = line_of(way);
        exp_start  = start_of(off);
        tick();
        req_valid = 1'b0;
        if (change) randomize_ways();
        obs_n = 0;
        hs_n  = 0;
        while (hs_n < BEATS && obs_n < 40) begin
            beat_ready = !(hs_n == stall_at && stalled < stall_len);
            if (!beat_ready) stalled++;
            sample(obs_n);
            if (beat_valid && beat_ready) begin
                hs_idx[hs_n]   = beat_idx;
                hs_data[hs_n]  = beat_data;
                hs_last[hs_n]  = beat_last;
                hs_cycle[hs_n] = obs_n;
                hs_n++;
            end
            obs_n++;
            tick();
        end
        beat_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_way    = '0;
        req_offset = '0;
        beat_ready = 1'b1;
        randomize_ways();
        repeat (2) @(posedge clock);
        @(negedge clock);
        n_checks++;
        if (req_ready !== 1'b1 || beat_valid !== 1'b0)
            $display("FAIL reset_hs: ready=%b valid=%b, expected 1 0",
                     req_ready, beat_valid);
        else n_pass++;
        n_checks++;
        if (beat_idx !== 3'd0 || beat_last !== 1'b0)
            $display("FAIL reset_idx: idx=%0d last=%b, expected 0 0",
                     beat_idx, beat_last);
        else n_pass++;
        n_checks++;
        if (way_err !== 1'b0 || beat_data !== 64'd0)
            $display("FAIL reset_data: err=%b data=%h, expected 0 0",
                     way_err, beat_data);
        else n_pass++;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_burst();
        for (int b = 0; b < BEATS; b++) begin
            ways[3][b*BEAT_W +: BEAT_W] = 64'h30 + 64'(b);
        end
        do_burst(3, 0, -1, 0, 1'b0);
        n_checks++;
        if (acc_ready !== 1'b1 || hs_n !== BEATS)
            $display("FAIL basic_count: ready=%b beats=%0d, expected 1 8",
                     acc_ready, hs_n);
        else n_pass++;
        n_checks++;
        if (hs_cycle[0] !== 0 || hs_cycle[BEATS-1] !== BEATS-1)
            $display("FAIL basic_timing: first=%0d last=%0d, expected 0 7",
                     hs_cycle[0], hs_cycle[BEATS-1]);
        else n_pass++;
        for (int k = 0; k < BEATS; k++) begin
            n_checks++;
            if (hs_idx[k] !== 3'(k) || hs_data[k] !== 64'h30 + 64'(k) ||
                hs_last[k] !== (k == BEATS-1))
                $display("FAIL basic_beat%0d: idx=%0d data=%h last=%b, expected %0d %h %b",
                         k, hs_idx[k], hs_data[k], hs_last[k],
                         k, 64'h30 + 64'(k), k == BEATS-1);
            else n_pass++;
        end
        n_checks++;
        if (way_err !== 1'b0)
            $display("FAIL basic_err: way_err=%b, expected 0", way_err);
        else n_pass++;
    endtask

    task automatic test_critical_word();
        for (int t = 0; t < 4; t++) begin
            int off = (t == 0) ? 5 : int'($urandom_range(0, BEATS-1));
            int way = int'($urandom_range(0, WAYS-1));
            randomize_ways();
            do_burst(way, off, -1, 0, 1'b0);
            n_checks++;
            if (hs_n !== BEATS || hs_cycle[BEATS-1] !== BEATS-1)
                $display("FAIL cwf_count t%0d: beats=%0d end=%0d, expected 8 7",
                         t, hs_n, hs_cycle[BEATS-1]);
            else n_pass++;
            for (int k = 0; k < BEATS; k++) begin
                int ei = (exp_start + k) % BEATS;
                n_checks++;
                if (hs_idx[k] !== 3'(ei) ||
                    hs_data[k] !== beat_of(exp_line, ei) ||
                    hs_last[k] !== (k == BEATS-1))
                    $display("FAIL cwf t%0d beat%0d: idx=%0d data=%h last=%b, expected %0d %h %b",
                             t, k, hs_idx[k], hs_data[k], hs_last[k],
                             ei, beat_of(exp_line, ei), k == BEATS-1);
                else n_pass++;
            end
        end
    endtask

    task automatic test_backpressure();
        int stalls = 0;
        randomize_ways();
        do_burst(int'($urandom_range(0, WAYS-1)),
                 int'($urandom_range(0, BEATS-1)), 2, 3, 1'b0);
        n_checks++;
        if (hs_n !== BEATS || hs_cycle[2] !== 5 || hs_cycle[BEATS-1] !== 10)
            $display("FAIL bp_timing: beats=%0d hs2=%0d end=%0d, expected 8 5 10",
                     hs_n, hs_cycle[2], hs_cycle[BEATS-1]);
        else n_pass++;
        for (int c = 0; c < obs_n; c++) begin
            if (obs_valid[c] && !obs_ready[c]) begin
                int ei = (exp_start + 2) % BEATS;
                stalls++;
                n_checks++;
                if (obs_idx[c] !== 3'(ei) ||
                    obs_data[c] !== beat_of(exp_line, ei) ||
                    obs_last[c] !== 1'b0)
                    $display("FAIL bp_hold c%0d: idx=%0d data=%h last=%b, expected %0d %h 0",
                             c, obs_idx[c], obs_data[c], obs_last[c],
                             ei, beat_of(exp_line, ei));
                else n_pass++;
            end
        end
        n_checks++;
        if (stalls !== 3)
            $display("FAIL bp_stalls: stalled=%0d, expected 3", stalls);
        else n_pass++;
        for (int k = 0; k < BEATS; k++) begin
            int ei = (exp_start + k) % BEATS;
            n_checks++;
            if (hs_idx[k] !== 3'(ei) ||
                hs_data[k] !== beat_of(exp_line, ei) ||
                hs_last[k] !== (k == BEATS-1))
                $display("FAIL bp_beat%0d: idx=%0d data=%h, expected %0d %h",
                         k, hs_idx[k], hs_data[k],
                         ei, beat_of(exp_line, ei));
            else n_pass++;
        end
    endtask

    task automatic test_out_of_range();
        randomize_ways();
        do_burst(7, int'($urandom_range(0, BEATS-1)), -1, 0, 1'b0);
        n_checks++;
        if (hs_n !== BEATS || way_err !== 1'b1)
            $display("FAIL oor_burst: beats=%0d way_err=%b, expected 8 1",
                     hs_n, way_err);
        else n_pass++;
        for (int k = 0; k < BEATS; k++) begin
            int ei = (exp_start + k) % BEATS;
            n_checks++;
            if (hs_data[k] !== 64'd0 || hs_idx[k] !== 3'(ei))
                $display("FAIL oor_beat%0d: idx=%0d data=%h, expected %0d 0",
                         k, hs_idx[k], hs_data[k], ei);
            else n_pass++;
        end
        do_burst(1, 0, -1, 0, 1'b0);
        n_checks++;
        if (way_err !== 1'b0 || hs_data[0] !== beat_of(exp_line, exp_start))
            $display("FAIL oor_clear: way_err=%b data=%h, expected 0 %h",
                     way_err, hs_data[0], beat_of(exp_line, exp_start));
        else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        randomize_ways();
        @(negedge clock);
        req_valid  = 1'b1;
        req_way    = 3'd2;
        req_offset = 3'd0;
        beat_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (4) tick();
        n_checks++;
        if (beat_valid !== 1'b1 || beat_idx !== 3'd4)
            $display("FAIL rst_pre: valid=%b idx=%0d, expected 1 4",
                     beat_valid, beat_idx);
        else n_pass++;
        reset_n = 1'b0;
        tick();
        n_checks++;
        if (beat_valid !== 1'b0 || req_ready !== 1'b1 || beat_idx !== 3'd0)
            $display("FAIL rst_mid: valid=%b ready=%b idx=%0d, expected 0 1 0",
                     beat_valid, req_ready, beat_idx);
        else n_pass++;
        reset_n = 1'b1;
        tick();
        n_checks++;
        if (beat_valid !== 1'b0)
            $display("FAIL rst_abandon: valid=%b, expected 0", beat_valid);
        else n_pass++;
        do_burst(4, 3, -1, 0, 1'b0);
        for (int k = 0; k < BEATS; k++) begin
            int ei = (exp_start + k) % BEATS;
            n_checks++;
            if (hs_idx[k] !== 3'(ei) ||
                hs_data[k] !== beat_of(exp_line, ei) ||
                hs_last[k] !== (k == BEATS-1))
                $display("FAIL rst_fresh beat%0d: idx=%0d data=%h, expected %0d %h",
                         k, hs_idx[k], hs_data[k],
                         ei, beat_of(exp_line, ei));
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int a  = int'($urandom_range(0, WAYS-1));
        int b  = (a + 1 + int'($urandom_range(0, WAYS-2))) % WAYS;
        int oa = int'($urandom_range(0, BEATS-1));
        int ob = int'($urandom_range(0, BEATS-1));
        logic [LINE_W-1:0] la;
        logic [LINE_W-1:0] lb;
        randomize_ways();
        @(negedge clock);
        req_valid  = 1'b1;
        req_way    = a[2:0];
        req_offset = oa[2:0];
        beat_ready = 1'b1;
        la = line_of(a);
        tick();
        req_way    = b[2:0];
        req_offset = ob[2:0];
        lb = '0;
        for (int c = 0; c < 18; c++) begin
            sample(c);
            if (c == 3) randomize_ways();
            if (c == 8) lb = line_of(b);
            tick();
            if (c == 8) req_valid = 1'b0;
        end
        for (int c = 0; c < 18; c++) begin
            bit   ev = (c <= 7) || (c >= 9 && c <= 16);
            int   k  = (c <= 7) ? c : c - 9;
            int   ei = ((c <= 7) ? start_of(oa) : start_of(ob)) + k;
            logic [63:0] ed;
            ei = ei % BEATS;
            ed = (c <= 7) ? beat_of(la, ei) : beat_of(lb, ei);
            n_checks++;
            if (obs_valid[c] !== ev || obs_rreq[c] !== !ev)
                $display("FAIL b2b_hs c%0d: valid=%b ready=%b, expected %b %b",
                         c, obs_valid[c], obs_rreq[c], ev, !ev);
            else n_pass++;
            if (ev) begin
                n_checks++;
                if (obs_idx[c] !== 3'(ei) || obs_data[c] !== ed ||
                    obs_last[c] !== (k == BEATS-1))
                    $display("FAIL b2b_beat c%0d: idx=%0d data=%h last=%b, expected %0d %h %b",
                             c, obs_idx[c], obs_data[c], obs_last[c],
                             ei, ed, k == BEATS-1);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_burst();
        test_critical_word();
        test_backpressure();
        test_out_of_range();
        test_reset_mid_burst();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
